// File: rtl/puf_eval_sched.sv
// puf_eval_sched: round-robin scheduler that shares one PUF evaluation core
// between NREQ requesters. Each granted request is evaluated VOTES times
// (reset -> settle -> enable -> ready), the response bits are majority-voted
// and the result is returned tagged with the requester id.
//
// Ports:
//   clk          system clock, rising edge
//   sys_rst_neg  asynchronous active-low reset
//   req_valid    per-requester request pending
//   req_chall    per-requester challenge, requester i in [i*CW +: CW]
//   req_ready    one-hot accept strobe (combinational, IDLE only)
//   rsp_valid    one-cycle result strobe
//   rsp_id       requester index of the result
//   rsp_data     majority-voted response (zero on timeout)
//   rsp_err      evaluation timed out
//   puf_rst_pos  PUF reset, active-high
//   puf_en       PUF enable
//   puf_chall    PUF challenge, held from grant until DONE
//   puf_response PUF response
//   puf_ready    PUF ready (level, synchronous to clk)
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | PUF held in reset, waiting for a request
// RST     | one cycle of PUF reset before an evaluation
// SETTLE  | reset released, enable still low, timer cleared
// EVAL    | PUF enabled, waiting for ready or timeout
// CAPTURE | accumulate captured response into vote counters
// DONE    | present result for one cycle

module puf_eval_sched #(
    parameter int NREQ    = 2,
    parameter int CW      = 8,
    parameter int RW      = 8,
    parameter int VOTES   = 3,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNTW   = $clog2(VOTES + 1)
) (
    input  logic                 clk,
    input  logic                 sys_rst_neg,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*CW-1:0]   req_chall,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [RW-1:0]        rsp_data,
    output logic                 rsp_err,
    output logic                 puf_rst_pos,
    output logic                 puf_en,
    output logic [CW-1:0]        puf_chall,
    input  logic [RW-1:0]        puf_response,
    input  logic                 puf_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_SETTLE, S_EVAL, S_CAPTURE, S_DONE
    } state_t;

    state_t                   state_q;
    logic [IDW-1:0]           rr_ptr_q;
    logic [IDW-1:0]           id_q;
    logic [CW-1:0]            chall_q;
    logic [RW-1:0]            cap_q;
    logic [RW-1:0][CNTW-1:0]  ones_q;
    logic [RW-1:0][CNTW-1:0]  ones_d;
    logic [RW-1:0]            maj_d;
    logic [CNTW-1:0]          vote_idx_q;
    logic [TO_W-1:0]          to_cnt_q;
    logic                     rst_pos_q;
    logic                     en_q;
    logic                     rsp_valid_q;
    logic [IDW-1:0]           rsp_id_q;
    logic [RW-1:0]            rsp_data_q;
    logic                     rsp_err_q;

    logic                     gnt_valid;
    logic [IDW-1:0]           gnt_idx;
    logic [IDW-1:0]           gnt_next;
    logic [IDW-1:0]           cand;
    logic [CW-1:0]            gnt_chall;

    // First pending requester at or above rr_ptr, wrapping.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!gnt_valid && req_valid[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt_next  = IDW'((int'(gnt_idx) + 1) % NREQ);
        gnt_chall = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_idx == IDW'(k)) begin
                gnt_chall = req_chall[k*CW +: CW];
            end
            // Gated by reset so the strobe is low while the block is held in reset.
            req_ready[k] = sys_rst_neg && (state_q == S_IDLE) && gnt_valid && (gnt_idx == IDW'(k));
        end
    end

    // Vote counters including the response captured in this CAPTURE cycle.
    always_comb begin
        for (int b = 0; b < RW; b++) begin
            ones_d[b] = ones_q[b] + CNTW'(cap_q[b]);
            maj_d[b]  = (ones_d[b] > CNTW'(VOTES / 2));
        end
    end

    always_ff @(posedge clk or negedge sys_rst_neg) begin
        if (!sys_rst_neg) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            chall_q     <= '0;
            cap_q       <= '0;
            ones_q      <= '0;
            vote_idx_q  <= '0;
            to_cnt_q    <= '0;
            rst_pos_q   <= 1'b1;
            en_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_valid) begin
                        chall_q    <= gnt_chall;
                        id_q       <= gnt_idx;
                        rr_ptr_q   <= gnt_next;
                        ones_q     <= '0;
                        vote_idx_q <= '0;
                        rst_pos_q  <= 1'b1;
                        en_q       <= 1'b0;
                        state_q    <= S_RST;
                    end
                end
                S_RST: begin
                    rst_pos_q <= 1'b0;
                    state_q   <= S_SETTLE;
                end
                S_SETTLE: begin
                    to_cnt_q <= '0;
                    en_q     <= 1'b1;
                    state_q  <= S_EVAL;
                end
                S_EVAL: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    // Ready takes priority over a coincident timeout.
                    if (puf_ready) begin
                        cap_q   <= puf_response;
                        en_q    <= 1'b0;
                        state_q <= S_CAPTURE;
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        en_q        <= 1'b0;
                        rst_pos_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_CAPTURE: begin
                    ones_q     <= ones_d;
                    vote_idx_q <= vote_idx_q + 1'b1;
                    rst_pos_q  <= 1'b1;
                    if (vote_idx_q == CNTW'(VOTES - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_data_q  <= maj_d;
                        rsp_err_q   <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        state_q <= S_RST;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign puf_rst_pos = rst_pos_q;
    assign puf_en      = en_q;
    assign puf_chall   = chall_q;

endmodule

// File: tb/tb_puf_eval_sched.sv
// Testbench for puf_eval_sched (NREQ=2, VOTES=3, TIMEOUT=200).
// A behavioural PUF model answers after a programmable number of enabled
// cycles; expected results are queued by the stimulus and compared by an
// independent monitor whenever the DUT grants or presents a response.

module tb_puf_eval_sched;

    logic        clk;
    logic        sys_rst_neg;
    logic [1:0]  req_valid;
    logic [15:0] req_chall;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        puf_rst_pos;
    logic        puf_en;
    logic [7:0]  puf_chall;
    logic [7:0]  puf_response;
    logic        puf_ready;

    puf_eval_sched #(
        .NREQ(2), .CW(8), .RW(8), .VOTES(3), .TO_W(8), .TIMEOUT(200)
    ) dut (
        .clk(clk), .sys_rst_neg(sys_rst_neg),
        .req_valid(req_valid), .req_chall(req_chall), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .puf_rst_pos(puf_rst_pos), .puf_en(puf_en), .puf_chall(puf_chall),
        .puf_response(puf_response), .puf_ready(puf_ready)
    );

    typedef struct {
        int         id;
        logic [7:0] chall;
        logic [7:0] data;
        logic       err;
        int         delay;
        int         pulses;
    } exp_t;

    exp_t       sb[$];
    int         exp_gnt[$];
    logic [7:0] resp_q[$];
    int         lat;
    int         checks;
    int         failures;
    int         cyc;
    int         n_rsp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h @cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic expect_rsp(input int id, input logic [7:0] ch, input logic [7:0] d,
                              input logic e, input int dly, input int p);
        exp_t x;
        x.id = id; x.chall = ch; x.data = d; x.err = e; x.delay = dly; x.pulses = p;
        sb.push_back(x);
        exp_gnt.push_back(id);
    endtask

    task automatic push_resp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        resp_q.push_back(a);
        resp_q.push_back(b);
        resp_q.push_back(c);
    endtask

    // Raise the request, wait for the accept strobe, present the same challenge n times.
    task automatic requester(input int id, input logic [7:0] ch, input int n);
        bit got;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            req_valid[id] = 1'b1;
            req_chall[id*8 +: 8] = ch;
            got = 1'b0;
            for (int t = 0; t < 4000 && !got; t++) begin
                @(negedge clk);
                if (req_ready[id]) got = 1'b1;
            end
            if (!got) chk($sformatf("req%0d_accept_timeout", id), 32'd0, 32'd1);
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
        chk("drain_pending", sb.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    // PUF model: ready for exactly one cycle after lat enabled cycles (lat=0: never).
    initial begin
        int en_cnt;
        puf_ready = 1'b0;
        puf_response = 8'h00;
        en_cnt = 0;
        forever begin
            @(negedge clk);
            if (puf_en) begin
                en_cnt++;
                if (lat != 0 && en_cnt == lat) begin
                    puf_ready = 1'b1;
                    puf_response = (resp_q.size() != 0) ? resp_q.pop_front() : 8'h00;
                end else begin
                    puf_ready = 1'b0;
                end
            end else begin
                en_cnt = 0;
                puf_ready = 1'b0;
            end
        end
    end

    // Monitor: grant order, PUF reset/enable sequencing, response scoreboard.
    initial begin
        int   acc_cyc;
        int   pulses;
        logic prev_rst, prev2_rst, prev_en;
        exp_t e;
        int   g;
        acc_cyc = 0; pulses = 0;
        prev_rst = 1'b1; prev2_rst = 1'b1; prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (!sys_rst_neg) begin
                prev_rst = 1'b1; prev2_rst = 1'b1; prev_en = 1'b0; pulses = 0;
            end else begin
                if (req_ready != 2'b00) begin
                    g = req_ready[1] ? 1 : 0;
                    chk("grant_onehot", {31'd0, req_ready[0] ^ req_ready[1]}, 32'd1);
                    if (exp_gnt.size() == 0) chk("grant_unexpected", g, 32'hFFFF_FFFF);
                    else chk("grant_id", g, exp_gnt.pop_front());
                    acc_cyc = cyc;
                    pulses = 0;
                end
                if (prev_rst && !puf_rst_pos) pulses++;
                if (puf_en && !prev_en)
                    chk("en_after_rst_settle", {30'd0, prev2_rst, prev_rst}, 32'd2);
                if (rsp_valid) begin
                    n_rsp++;
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", {31'd0, rsp_id}, e.id);
                        chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
                        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        chk("rsp_cycle", cyc - acc_cyc, e.delay);
                        chk("rst_pulses", pulses, e.pulses);
                        chk("puf_chall", {24'd0, puf_chall}, {24'd0, e.chall});
                    end
                end
                prev2_rst = prev_rst;
                prev_rst = puf_rst_pos;
                prev_en = puf_en;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_puf_rst_pos"}, {31'd0, puf_rst_pos}, 32'd1);
        chk({tag, "_puf_en"}, {31'd0, puf_en}, 32'd0);
        chk({tag, "_puf_chall"}, {24'd0, puf_chall}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
        chk({tag, "_rsp_data"}, {24'd0, rsp_data}, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
    endtask

    initial begin
        int n_before;
        checks = 0; failures = 0; cyc = 0; n_rsp = 0; lat = 20;
        sys_rst_neg = 1'b0;
        req_valid = 2'b11;
        req_chall = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        req_valid = 2'b00;
        @(posedge clk); #1;
        sys_rst_neg = 1'b1;
        repeat (2) @(posedge clk);

        // Single request, unanimous votes, L=20: 1+3*23 = 70.
        lat = 20;
        push_resp(8'hA5, 8'hA5, 8'hA5);
        expect_rsp(0, 8'h01, 8'hA5, 1'b0, 70, 3);
        requester(0, 8'h01, 1);
        drain();

        // Majority vote of A5, A4, 25 -> A5; L=5: 1+3*8 = 25.
        lat = 5;
        push_resp(8'hA5, 8'hA4, 8'h25);
        expect_rsp(1, 8'h33, 8'hA5, 1'b0, 25, 3);
        requester(1, 8'h33, 1);
        drain();

        // Round-robin with both requesters continuously valid; L=3: 1+3*6 = 19.
        lat = 3;
        push_resp(8'h11, 8'h11, 8'h11);
        push_resp(8'h22, 8'h22, 8'h22);
        push_resp(8'h33, 8'h33, 8'h33);
        push_resp(8'h44, 8'h44, 8'h44);
        expect_rsp(0, 8'hC1, 8'h11, 1'b0, 19, 3);
        expect_rsp(1, 8'h2C, 8'h22, 1'b0, 19, 3);
        expect_rsp(0, 8'hC1, 8'h33, 1'b0, 19, 3);
        expect_rsp(1, 8'h2C, 8'h44, 1'b0, 19, 3);
        fork
            requester(0, 8'hC1, 2);
            requester(1, 8'h2C, 2);
        join
        drain();

        // Timeout in the first evaluation: 3+200 = 203, then a normal request.
        lat = 0;
        expect_rsp(0, 8'h77, 8'h00, 1'b1, 203, 1);
        requester(0, 8'h77, 1);
        drain();
        lat = 2;
        push_resp(8'h3C, 8'h3C, 8'h3C);
        expect_rsp(1, 8'h0F, 8'h3C, 1'b0, 16, 3);
        requester(1, 8'h0F, 1);
        drain();

        // Ready in the 200th EVAL cycle coincides with timeout: ready wins.
        lat = 200;
        push_resp(8'h5A, 8'h5A, 8'h5A);
        expect_rsp(0, 8'h99, 8'h5A, 1'b0, 610, 3);
        requester(0, 8'h99, 1);
        drain();

        // Reset during the second EVAL: outputs revert at once, no response.
        lat = 10;
        push_resp(8'hE1, 8'hE2, 8'hE3);
        exp_gnt.push_back(1);
        n_before = n_rsp;
        requester(1, 8'hEE, 1);
        repeat (16) @(posedge clk);
        #1;
        chk("mid_eval_puf_en", {31'd0, puf_en}, 32'd1);
        sys_rst_neg = 1'b0;
        #1;
        check_reset_outputs("midreset");
        resp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        sys_rst_neg = 1'b1;
        repeat (3) @(posedge clk);
        chk("no_rsp_after_abort", n_rsp, n_before);

        // After reset release requester 0 has priority again; L=1: 1+3*4 = 13.
        lat = 1;
        push_resp(8'h0F, 8'h0F, 8'h0F);
        push_resp(8'hF0, 8'hF0, 8'hF0);
        expect_rsp(0, 8'hAB, 8'h0F, 1'b0, 13, 3);
        expect_rsp(1, 8'hCD, 8'hF0, 1'b0, 13, 3);
        fork
            requester(0, 8'hAB, 1);
            requester(1, 8'hCD, 1);
        join
        drain();
        chk("grants_consumed", exp_gnt.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
